// File: rtl/midori_sbox_seq_pkg.sv
// Shared types and defaults for the masked Midori S-box layer sequencer.
// Holds the controller state encoding and the layout of the per-call PRNG word.
package midori_sbox_seq_pkg;

    localparam int NUM_NIB_DEF = 16;
    localparam int RND_W_DEF   = 24;
    localparam int STAGES_DEF  = 3;
    localparam int IDX_W       = 4;
    localparam int FIELD_W     = 6;

    // Bit offsets of the 6-bit refresh masks inside rnd_data.
    localparam int R1_OFF = 0;
    localparam int R2_OFF = 6;
    localparam int R3_OFF = 12;
    localparam int RS_OFF = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [FIELD_W-1:0] rnd_field(input logic [RND_W_DEF-1:0] word,
                                                     input int off);
        return word[off +: FIELD_W];
    endfunction

endpackage

// File: rtl/midori_rnd_pipe.sv
// Token shift chain: valid bit, nibble index and bound randomness per stage.
// Bubbles load zero so no stale PRNG word survives in any stage.
module midori_rnd_pipe
    import midori_sbox_seq_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int RND_W  = RND_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fire_i,
    input  logic [IDX_W-1:0]              idx_i,
    input  logic [RND_W-1:0]              rnd_i,
    output logic [STAGES-1:0]             vld_o,
    output logic [IDX_W-1:0]              idx_o,
    output logic [STAGES-1:0][RND_W-1:0]  rnd_o
);

    logic [STAGES-1:0]             vld_q;
    logic [STAGES-1:0][IDX_W-1:0]  idx_q;
    logic [STAGES-1:0][RND_W-1:0]  rnd_q;

    // Advance every stage each cycle; there is no back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
            rnd_q <= '0;
        end else begin
            vld_q    <= {vld_q[STAGES-2:0], fire_i};
            idx_q[0] <= fire_i ? idx_i : {IDX_W{1'b0}};
            rnd_q[0] <= fire_i ? rnd_i : {RND_W{1'b0}};
            for (int k = 1; k < STAGES; k++) begin
                idx_q[k] <= idx_q[k-1];
                rnd_q[k] <= rnd_q[k-1];
            end
        end
    end

    assign vld_o = vld_q;
    assign idx_o = idx_q[STAGES-1];
    assign rnd_o = rnd_q;

endmodule

// File: rtl/midori_sbox_seq.sv
// Sequencer for one masked S-box layer: issues NUM_NIB nibbles, one per PRNG word,
// into a STAGES-deep pipeline and reports each result as it leaves the last stage.
module midori_sbox_seq
    import midori_sbox_seq_pkg::*;
#(
    parameter int NUM_NIB = NUM_NIB_DEF,
    parameter int RND_W   = RND_W_DEF,
    parameter int STAGES  = STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rnd_valid,
    input  logic [RND_W-1:0]  rnd_data,
    output logic              rnd_ready,
    output logic [3:0]        issue_idx,
    output logic [STAGES-1:0] stage_en,
    output logic [RND_W-1:0]  rnd_st1,
    output logic [RND_W-1:0]  rnd_st2,
    output logic [RND_W-1:0]  rnd_st3,
    output logic              wr_en,
    output logic [3:0]        wr_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_NIB - 1);

    state_e                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic                         busy_q, done_q;
    logic                         fire;
    logic [STAGES-1:0]            vld;
    logic [3:0]                   idx_last;
    logic [STAGES-1:0][RND_W-1:0] rnd_pipe;

    assign rnd_ready = (state_q == ST_RUN);
    assign fire      = rnd_valid & rnd_ready;

    midori_rnd_pipe #(
        .STAGES (STAGES),
        .RND_W  (RND_W)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .fire_i (fire),
        .idx_i  (cnt_q),
        .rnd_i  (rnd_data),
        .vld_o  (vld),
        .idx_o  (idx_last),
        .rnd_o  (rnd_pipe)
    );

    // Next-state and issue-counter logic; the counter holds on the final issue.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (fire) begin
                    if (cnt_q == LAST_IDX) state_d = ST_DRAIN;
                    else                   cnt_d   = cnt_q + 4'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (vld == '0) state_d = ST_DONE;
                else           state_d = ST_DRAIN;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign issue_idx = cnt_q;
    assign stage_en  = vld;
    assign rnd_st1   = rnd_pipe[0];
    assign rnd_st2   = rnd_pipe[1];
    assign rnd_st3   = rnd_pipe[STAGES-1];
    assign wr_en     = vld[STAGES-1];
    assign wr_idx    = idx_last;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_midori_sbox_seq.sv
// Directed bench for midori_sbox_seq: a cycle model predicts control outputs and a
// scoreboard queue holds each issued token until it is due to leave the pipeline.
module tb_midori_sbox_seq;

    localparam int N  = 16;
    localparam int RW = 24;

    logic          clk = 1'b0;
    logic          rst, start, rnd_valid;
    logic [RW-1:0] rnd_data;
    logic          rnd_ready, wr_en, busy, done;
    logic [3:0]    issue_idx, wr_idx;
    logic [2:0]    stage_en;
    logic [RW-1:0] rnd_st1, rnd_st2, rnd_st3;

    logic          s_start, s_valid;
    logic [RW-1:0] s_data;
    logic          s_ready, s_wr_en, s_busy, s_done;
    logic [3:0]    s_issue_idx, s_wr_idx;
    logic [2:0]    s_stage_en;
    logic [RW-1:0] s_st1, s_st2, s_st3;

    always #5 clk = ~clk;

    midori_sbox_seq #(.NUM_NIB(N), .RND_W(RW), .STAGES(3)) dut (
        .clk(clk), .rst(rst), .start(start), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
        .rnd_ready(rnd_ready), .issue_idx(issue_idx), .stage_en(stage_en),
        .rnd_st1(rnd_st1), .rnd_st2(rnd_st2), .rnd_st3(rnd_st3),
        .wr_en(wr_en), .wr_idx(wr_idx), .busy(busy), .done(done)
    );

    midori_sbox_seq #(.NUM_NIB(1), .RND_W(RW), .STAGES(3)) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .rnd_valid(s_valid), .rnd_data(s_data),
        .rnd_ready(s_ready), .issue_idx(s_issue_idx), .stage_en(s_stage_en),
        .rnd_st1(s_st1), .rnd_st2(s_st2), .rnd_st3(s_st3),
        .wr_en(s_wr_en), .wr_idx(s_wr_idx), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        logic [3:0]    idx;
        logic [RW-1:0] rnd;
        int            due;
    } tok_t;

    tok_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    int            n_wr  = 0;
    int            n_done = 0;
    int            m_state;
    logic [3:0]    m_cnt;
    logic [2:0]    m_fh;
    logic [RW-1:0] m_rh [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 4'd0;
        m_fh    = 3'b000;
        for (int i = 0; i < 3; i++) m_rh[i] = '0;
        sb.delete();
    endtask

    // Check the current cycle, advance the model with the driven inputs, cross one edge.
    task automatic tick();
        logic exp_wr;
        logic fire;
        tok_t t;
        #1;
        exp_wr = (sb.size() > 0) && (sb[0].due == cyc);
        chk("rnd_ready", 32'(rnd_ready), 32'(m_state == 1));
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("done", 32'(done), 32'(m_state == 3));
        if (m_state <= 1) chk("issue_idx", 32'(issue_idx), 32'(m_cnt));
        chk("stage_en", 32'(stage_en), 32'(m_fh));
        chk("rnd_st1", 32'(rnd_st1), 32'(m_rh[0]));
        chk("rnd_st2", 32'(rnd_st2), 32'(m_rh[1]));
        chk("wr_en", 32'(wr_en), 32'(exp_wr));
        if (exp_wr) begin
            t = sb.pop_front();
            chk("wr_idx", 32'(wr_idx), 32'(t.idx));
            chk("rnd_st3_bind", 32'(rnd_st3), 32'(t.rnd));
        end else begin
            chk("rnd_st3", 32'(rnd_st3), 32'(m_rh[2]));
        end
        if (wr_en === 1'b1) n_wr++;
        if (done === 1'b1) n_done++;

        fire = (m_state == 1) && rnd_valid && !rst;
        if (rst) begin
            model_reset();
        end else begin
            if (fire) sb.push_back('{m_cnt, rnd_data, cyc + 3});
            case (m_state)
                0: if (start) m_state = 1;
                1: if (fire) begin
                       if (m_cnt == 4'(N - 1)) m_state = 2;
                       else m_cnt = m_cnt + 4'd1;
                   end
                2: if (m_fh == 3'b000) m_state = 3;
                default: begin m_state = 0; m_cnt = 4'd0; end
            endcase
            m_rh[2] = m_rh[1];
            m_rh[1] = m_rh[0];
            m_rh[0] = fire ? rnd_data : '0;
            m_fh    = {m_fh[1:0], fire};
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, done0;
        bit hit;
        rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_data = '0;
        s_start = 1'b0; s_valid = 1'b0; s_data = '0;
        @(posedge clk); #1;
        model_reset();

        // Reset held for two cycles
        tick();
        chk("rst_wr_idx", 32'(wr_idx), 32'd0);
        chk("rst_issue_idx", 32'(issue_idx), 32'd0);
        chk("rst_st3", 32'(rnd_st3), 32'd0);
        tick();
        rst = 1'b0;

        // Basic run with rnd_data = k; start re-pulsed in RUN and in DRAIN
        wr0 = n_wr; done0 = n_done;
        rnd_valid = 1'b1;
        for (int i = 0; i < 26; i++) begin
            start    = (i == 0) || (i == 5) || (i == 18);
            rnd_data = 24'(m_cnt);
            tick();
        end
        start = 1'b0;
        chk("basic_wr_count", 32'(n_wr - wr0), 32'd16);
        chk("basic_done_count", 32'(n_done - done0), 32'd1);
        chk("basic_sb_empty", 32'(sb.size()), 32'd0);

        // PRNG stalls: valid pattern 1,0,0 with junk data on bubble cycles
        wr0 = n_wr; done0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rnd_valid = ((i % 3) == 0);
            rnd_data  = rnd_valid ? (24'hC5A000 + 24'(m_cnt)) : 24'hFFFFFF;
            tick();
        end
        chk("stall_wr_count", 32'(n_wr - wr0), 32'd16);
        chk("stall_done_count", 32'(n_done - done0), 32'd1);

        // Reset in the cycle result 5 leaves the pipeline
        wr0 = n_wr;
        hit = 1'b0;
        rnd_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            rnd_data = 24'h3C0000 + 24'(m_cnt);
            if (sb.size() > 0 && sb[0].due == cyc && sb[0].idx == 4'd5) begin
                hit = 1'b1;
                rst = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        chk("rst_point_reached", 32'(hit), 32'd1);
        chk("rst_mid_wr_idx", 32'(wr_idx), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        wr0 = n_wr;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_no_more_wr", 32'(n_wr - wr0), 32'd0);

        // Restart after reset begins again from index 0
        wr0 = n_wr; done0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rnd_data = 24'h5A0000 + 24'(m_cnt);
            tick();
        end
        chk("restart_wr_count", 32'(n_wr - wr0), 32'd16);
        chk("restart_done_count", 32'(n_done - done0), 32'd1);
        rnd_valid = 1'b0;

        // Single-nibble layer
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; s_valid = 1'b1; s_data = 24'hABCDEF;
        #1; chk("n1_ready_run", 32'(s_ready), 32'd1);
        @(posedge clk); #2;
        s_valid = 1'b0;
        chk("n1_ready_drain", 32'(s_ready), 32'd0);
        chk("n1_stage1", 32'(s_stage_en), 32'b001);
        chk("n1_st1", 32'(s_st1), 32'hABCDEF);
        @(posedge clk); #2;
        chk("n1_stage2", 32'(s_stage_en), 32'b010);
        @(posedge clk); #2;
        chk("n1_wr_en", 32'(s_wr_en), 32'd1);
        chk("n1_wr_idx", 32'(s_wr_idx), 32'd0);
        chk("n1_st3", 32'(s_st3), 32'hABCDEF);
        @(posedge clk); #2;
        chk("n1_wr_off", 32'(s_wr_en), 32'd0);
        chk("n1_busy_drain", 32'(s_busy), 32'd1);
        chk("n1_done_early", 32'(s_done), 32'd0);
        @(posedge clk); #2;
        chk("n1_done", 32'(s_done), 32'd1);
        @(posedge clk); #2;
        chk("n1_done_off", 32'(s_done), 32'd0);
        chk("n1_idle", 32'(s_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
